mult_rr_sched: RTL and testbench
================================

# mult_rr_sched

Round-robin scheduler that shares one shift-add multiplier among `N_REQ` requesters. It arbitrates pending requests, loads the winner's operands into the multiplier, pulses the multiplier's start, and waits for done. It then returns the product to the winner with a one-cycle response strobe. It sits between the client ports and a single multiplier instance, and a watchdog turns a hung multiplier into an error response.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, maximum cycles from start to done before an error response
- Operand width is `width_p` from `mult_types`; product width is `2*width_p`

Ports:
- `clk_i` in 1: single clock, rising edge
- `reset_n_i` in 1: reset, asynchronous, active-low
- `req_i` in N_REQ: per-requester request level; held until its `rsp_valid_o` bit
- `multiplicand_i` in N_REQ x width_p: per-requester operand A, stable while req high
- `multiplier_i` in N_REQ x width_p: per-requester operand B, stable while req high
- `rsp_valid_o` out N_REQ: one-hot, one-cycle response strobe
- `rsp_product_o` out 2*width_p: product, valid with strobe
- `rsp_err_o` out 1: timeout flag, valid with strobe
- `mult_start_o` out 1: one-cycle start to multiplier
- `mult_multiplicand_o` out width_p: latched operand A
- `mult_multiplier_o` out width_p: latched operand B
- `mult_ready_i` in 1: multiplier idle
- `mult_done_i` in 1: multiplier result valid
- `mult_product_i` in 2*width_p: multiplier result
- `busy_o` out 1: FSM not in IDLE
- `grant_idx_o` out $clog2(N_REQ): index of current/last grant

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `|req_i` and `mult_ready_i`, pick the winner with round-robin starting at pointer `ptr`.
  - Latch the winner's operands and `grant_idx`, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Assert `mult_start_o` for exactly one cycle, clear the watchdog counter, then go to WAIT.
- WAIT:
  - On `mult_done_i`, capture `mult_product_i`, set err=0, and go to RESP.
  - If `mult_done_i` has not arrived when the counter reaches `TIMEOUT-1`, set product=0, err=1, and go to RESP.
  - Done wins if it arrives in the same cycle as the timeout.
- RESP:
  - Assert `rsp_valid_o[grant_idx]` for one cycle.
  - Set `ptr <= grant_idx+1`, wrapping modulo `N_REQ`, then go to IDLE.
- The requester deasserts `req_i` in the cycle after its strobe. IDLE ignores a request still high in that cycle only through the pointer rotation; holding req longer means a new request.
- `mult_*` operand outputs hold their latched values from ISSUE until the next grant.
- Reset values:
  - State IDLE, `ptr`=0, `grant_idx_o`=0.
  - All strobes 0, `mult_start_o`=0, `busy_o`=0.
  - Operand, product and err registers 0.
- Reset asserted mid-operation aborts the transaction immediately, with no response. The multiplier is reset by the same net.
- `req_i` changes for non-granted requesters during a transaction have no effect; arbitration only happens in IDLE.

## Timing
- Latency from grant (IDLE edge) to start: 1 cycle. From done to response strobe: 1 cycle (RESP registered).
- Minimum turnaround: IDLE→ISSUE→WAIT→(done)→RESP→IDLE. Back-to-back grants are separated by at least one IDLE cycle.
- All outputs are registered; there are no combinational paths from `req_i` or `mult_*_i` to outputs.
- The watchdog counter width is $clog2(TIMEOUT)+1 and it saturates (never wraps).

## Structure
- Package `mult_sched_types`: state enum `sched_state_e`, default `TIMEOUT`, and the index-width function. It imports `width_p` from `mult_types`.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are the `req` vector and `ptr`; outputs are the one-hot grant, the index and `any`. Implement it as a doubled-vector priority search.
- Top level: FSM, operand latches, watchdog counter, response registers.

## Test plan
- Single request: req[2]=1, A=7, B=9; multiplier done after 17 cycles → `mult_start_o` pulses once, `rsp_valid_o`=4'b0100 for 1 cycle, product=63, err=0.
- Fairness: req=4'b1111 held and re-raised after each response, `ptr`=0 → grant order 0,1,2,3,0; no requester is served twice before the others.
- Timeout: stub multiplier never asserts done → strobe at exactly `TIMEOUT` cycles after start, err=1, product=0. A subsequent request is served normally.
- Done coincident with timeout: done arrives at counter `TIMEOUT-1` → err=0, product taken from `mult_product_i`.
- Ready low: req[1]=1 while `mult_ready_i`=0 → FSM stays IDLE and there is no start. When ready rises, start follows 1 cycle after the grant.
- Reset mid-WAIT: drop `reset_n_i` asynchronously → all outputs 0 immediately, no strobe. After release, req[3] is granted with `ptr`=0 ordering.

Source files
------------

// File: rtl/mult_rr_sched_pkg.sv
// Scheduler types: FSM states, default watchdog limit, index width helper.
package mult_sched_types;
    import mult_types::width_p;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_e;

    localparam int timeout_def_c = 64;
    localparam int prod_w_c      = 2 * width_p;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mult_types.sv
// Shared datapath widths for the multiplier subsystem.
package mult_types;
    localparam int width_p = 8;
endpackage

// File: rtl/mult_rr_sched_rr_pick.sv
// Combinational round-robin selector: first request at or after ptr,
// found by scanning the request vector concatenated with itself.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [2*N-1:0] dbl;
    int             pos;

    always_comb begin
        dbl   = {req_i, req_i};
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < 2 * N; k++) begin
            if (!any_o && (k >= int'(ptr_i)) && dbl[k]) begin
                any_o = 1'b1;
                pos   = k;
            end
        end
        if (pos >= N) pos = pos - N;
        idx_o = IW'(pos);
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one shift-add multiplier among N_REQ
// requesters, with a watchdog that turns a hung multiplier into an error.
module mult_rr_sched
    import mult_types::*;
    import mult_sched_types::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = timeout_def_c,
    localparam int IW     = idx_w(N_REQ),
    localparam int PW     = 2 * width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*width_p-1:0] multiplicand_i,
    input  logic [N_REQ*width_p-1:0] multiplier_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    output logic [PW-1:0]            rsp_product_o,
    output logic                     rsp_err_o,
    output logic                     mult_start_o,
    output logic [width_p-1:0]       mult_multiplicand_o,
    output logic [width_p-1:0]       mult_multiplier_o,
    input  logic                     mult_ready_i,
    input  logic                     mult_done_i,
    input  logic [PW-1:0]            mult_product_i,
    output logic                     busy_o,
    output logic [IW-1:0]            grant_idx_o
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    sched_state_e       state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [width_p-1:0] a_q, a_d;
    logic [width_p-1:0] b_q, b_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               err_q, err_d;
    logic [N_REQ-1:0]   rsp_q, rsp_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      cnt_inc;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Watchdog saturates rather than wrapping back into range.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rsp_d   = '0;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any && mult_ready_i) begin
                    gidx_d  = pick_idx;
                    gnt_d   = pick_gnt;
                    a_d     = multiplicand_i[int'(pick_idx)*width_p +: width_p];
                    b_d     = multiplier_i[int'(pick_idx)*width_p +: width_p];
                    cnt_d   = '0;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = cnt_inc;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done_i) begin
                    prod_d  = mult_product_i;
                    err_d   = 1'b0;
                    rsp_d   = gnt_q;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    rsp_d   = gnt_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rsp_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign rsp_valid_o         = rsp_q;
    assign rsp_product_o       = prod_q;
    assign rsp_err_o           = err_q;
    assign mult_start_o        = start_q;
    assign mult_multiplicand_o = a_q;
    assign mult_multiplier_o   = b_q;
    assign busy_o              = busy_q;
    assign grant_idx_o         = gidx_q;
endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: directed scenarios plus random traffic against
// a timestamp-based transaction model and a stub multiplier.
module tb_mult_rr_sched;
    import mult_types::*;

    localparam int N  = 4;
    localparam int TO = 64;
    localparam int W  = width_p;
    localparam int IW = $clog2(N);

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     mcand, mplier;
    logic [N-1:0]       rsp_valid;
    logic [2*W-1:0]     rsp_prod;
    logic               rsp_err;
    logic               mstart;
    logic [W-1:0]       mo_a, mo_b;
    logic               mready, mdone;
    logic [2*W-1:0]     mprod;
    logic               busy;
    logic [IW-1:0]      gidx;

    mult_rr_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .req_i               (req),
        .multiplicand_i      (mcand),
        .multiplier_i        (mplier),
        .rsp_valid_o         (rsp_valid),
        .rsp_product_o       (rsp_prod),
        .rsp_err_o           (rsp_err),
        .mult_start_o        (mstart),
        .mult_multiplicand_o (mo_a),
        .mult_multiplier_o   (mo_b),
        .mult_ready_i        (mready),
        .mult_done_i         (mdone),
        .mult_product_i      (mprod),
        .busy_o              (busy),
        .grant_idx_o         (gidx)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // requesters
    logic [N-1:0] req_v, pend_raise;
    logic [W-1:0] opa[N], opb[N];
    bit           refill, rand_mode, ready_force;
    // stub multiplier
    int           stub_lat, done_cyc;
    logic [W-1:0] st_a, st_b;
    // transaction model: state is a set of timestamps
    bit             m_act;
    int             m_start, m_resp, m_grant, m_ptr;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_prod;
    bit             m_err;
    logic [N-1:0]   e_rsp;
    bit             e_start, e_busy;
    // observation log
    int             start_cnt, start_cyc, strobe_cyc;
    logic [N-1:0]   last_rsp;
    logic [2*W-1:0] last_prod;
    logic           last_err;
    int             glog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive();
        req = req_v;
        for (int i = 0; i < N; i++) begin
            mcand[i*W +: W]  = opa[i];
            mplier[i*W +: W] = opb[i];
        end
        mready = rand_mode ? ($urandom_range(4) != 0) : ready_force;
        mdone  = (cyc == done_cyc);
        mprod  = (2*W)'(st_a) * (2*W)'(st_b);
    endtask

    task automatic model_reset();
        m_act = 0; m_start = -100; m_resp = -1; m_grant = 0; m_ptr = 0;
        m_a = '0; m_b = '0; m_prod = '0; m_err = 0;
        e_rsp = '0; e_start = 0; e_busy = 0;
        req_v = '0; pend_raise = '0; done_cyc = -1;
        st_a = '0; st_b = '0;
    endtask

    task automatic compare();
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("mult_start", 32'(mstart), 32'(e_start));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant_idx", 32'(gidx), 32'(m_grant));
        chk("op_a", 32'(mo_a), 32'(m_a));
        chk("op_b", 32'(mo_b), 32'(m_b));
        if (e_rsp != '0) begin
            chk("rsp_product", 32'(rsp_prod), 32'(m_prod));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
    endtask

    task automatic observe_and_stim();
        logic [N-1:0] dropped;
        int lat;
        dropped = '0;
        for (int i = 0; i < N; i++)
            if (pend_raise[i]) begin req_v[i] = 1'b1; pend_raise[i] = 1'b0; end
        if (mstart) begin
            start_cnt++;
            start_cyc = cyc;
            st_a = mo_a;
            st_b = mo_b;
            if (rand_mode) begin
                lat = $urandom_range(9);
                lat = (lat == 0) ? 0 : (lat == 1) ? TO - 1 : $urandom_range(40, 1);
            end else begin
                lat = stub_lat;
            end
            done_cyc = (lat > 0) ? cyc + lat : -1;
        end
        if (rsp_valid != '0) begin
            strobe_cyc = cyc;
            last_rsp   = rsp_valid;
            last_prod  = rsp_prod;
            last_err   = rsp_err;
            for (int i = 0; i < N; i++)
                if (rsp_valid[i]) begin
                    glog.push_back(i);
                    req_v[i]   = 1'b0;
                    dropped[i] = 1'b1;
                    if (refill) pend_raise[i] = 1'b1;
                end
        end
        if (rand_mode)
            for (int i = 0; i < N; i++)
                if (!req_v[i] && !dropped[i] && $urandom_range(7) == 0) begin
                    req_v[i] = 1'b1;
                    opa[i]   = W'($urandom);
                    opb[i]   = W'($urandom);
                end
        drive();
    endtask

    // Predict outputs of the next cycle from the inputs presented now.
    task automatic model_next();
        int n;
        n = cyc;
        if (!m_act) begin
            if (mready && (req != '0)) begin
                for (int k = 0; k < N; k++)
                    if (req[(m_ptr + k) % N]) begin
                        m_grant = (m_ptr + k) % N;
                        break;
                    end
                m_a = opa[m_grant];
                m_b = opb[m_grant];
                m_start = n + 1;
                m_resp = -1;
                m_act = 1;
            end
        end else if (m_resp == n) begin
            m_act = 0;
            m_ptr = (m_grant + 1) % N;
        end else if (n > m_start && m_resp < 0) begin
            if (mdone) begin
                m_resp = n + 1;
                m_prod = (2*W)'(m_a) * (2*W)'(m_b);
                m_err  = 0;
            end else if (n - m_start == TO - 1) begin
                m_resp = n + 1;
                m_prod = '0;
                m_err  = 1;
            end
        end
        e_start = (m_start == n + 1);
        e_busy  = m_act;
        e_rsp   = (m_resp == n + 1) ? (N'(1) << m_grant) : '0;
    endtask

    task automatic step();
        compare();
        observe_and_stim();
        model_next();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input int k, input int maxc);
        int target;
        target = glog.size() + k;
        for (int i = 0; i < maxc && glog.size() < target; i++) step();
        chk("strobe_within_bound", 32'(glog.size() >= target), 32'd1);
    endtask

    task automatic apply_reset(input bit mid);
        if (mid) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_start", 32'(mstart), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_gidx", 32'(gidx), 32'd0);
            chk("rst_op_a", 32'(mo_a), 32'd0);
            chk("rst_prod", 32'(rsp_prod), 32'd0);
        end else begin
            rst_n = 1'b0;
        end
        model_reset();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
    endtask

    initial begin
        int rise;
        rst_n = 1'b0;
        rand_mode = 0; ready_force = 1; refill = 0; stub_lat = 0;
        start_cnt = 0; start_cyc = 0; strobe_cyc = 0;
        last_rsp = '0; last_prod = '0; last_err = 0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        model_reset();
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single request, done 17 cycles after start
        stub_lat = 17; start_cnt = 0;
        opa[2] = 8'd7; opb[2] = 8'd9; req_v[2] = 1'b1;
        run_until(1, 100);
        chk("single_start_count", 32'(start_cnt), 32'd1);
        chk("single_rsp", 32'(last_rsp), 32'b0100);
        chk("single_product", 32'(last_prod), 32'd63);
        chk("single_err", 32'(last_err), 32'd0);
        chk("single_latency", 32'(strobe_cyc - start_cyc), 32'd18);
        for (int i = 0; i < 3; i++) step();

        // fairness from ptr=0
        apply_reset(0);
        glog.delete();
        stub_lat = 3; refill = 1;
        for (int i = 0; i < N; i++) begin
            opa[i] = W'(i + 1); opb[i] = 8'd2; req_v[i] = 1'b1;
        end
        run_until(5, 200);
        refill = 0; req_v = '0; pend_raise = '0;
        if (glog.size() >= 5) begin
            chk("fair_0", 32'(glog[0]), 32'd0);
            chk("fair_1", 32'(glog[1]), 32'd1);
            chk("fair_2", 32'(glog[2]), 32'd2);
            chk("fair_3", 32'(glog[3]), 32'd3);
            chk("fair_4", 32'(glog[4]), 32'd0);
        end
        for (int i = 0; i < 12; i++) step();

        // watchdog timeout, then a normal request
        stub_lat = 0;
        opa[0] = 8'd5; opb[0] = 8'd6; req_v[0] = 1'b1;
        run_until(1, 200);
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_product", 32'(last_prod), 32'd0);
        chk("to_latency", 32'(strobe_cyc - start_cyc), 32'(TO));
        step();
        stub_lat = 5;
        opa[1] = 8'd3; opb[1] = 8'd5; req_v[1] = 1'b1;
        run_until(1, 100);
        chk("after_to_rsp", 32'(last_rsp), 32'b0010);
        chk("after_to_product", 32'(last_prod), 32'd15);
        chk("after_to_err", 32'(last_err), 32'd0);
        step();

        // done coincident with the timeout
        stub_lat = TO - 1;
        opa[2] = 8'd12; opb[2] = 8'd11; req_v[2] = 1'b1;
        run_until(1, 200);
        chk("coinc_err", 32'(last_err), 32'd0);
        chk("coinc_product", 32'(last_prod), 32'd132);
        chk("coinc_latency", 32'(strobe_cyc - start_cyc), 32'(TO));
        step();

        // multiplier not ready
        ready_force = 0; start_cnt = 0; stub_lat = 2;
        opa[1] = 8'd4; opb[1] = 8'd4; req_v[1] = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("notready_no_start", 32'(start_cnt), 32'd0);
        chk("notready_idle", 32'(busy), 32'd0);
        ready_force = 1;
        rise = cyc;
        run_until(1, 50);
        chk("ready_start_count", 32'(start_cnt), 32'd1);
        chk("ready_start_cycle", 32'(start_cyc - rise), 32'd1);
        chk("ready_product", 32'(last_prod), 32'd16);
        step();

        // reset in the middle of WAIT
        stub_lat = 0; start_cnt = 0;
        opa[2] = 8'd9; opb[2] = 8'd9; req_v[2] = 1'b1;
        for (int i = 0; i < 20 && start_cnt == 0; i++) step();
        for (int i = 0; i < 5; i++) step();
        apply_reset(1);
        stub_lat = 4;
        opa[3] = 8'd2; opb[3] = 8'd10; req_v[3] = 1'b1;
        run_until(1, 50);
        chk("post_rst_rsp", 32'(last_rsp), 32'b1000);
        chk("post_rst_product", 32'(last_prod), 32'd20);
        step();

        // random traffic
        rand_mode = 1;
        for (int i = 0; i < 8000; i++) begin
            if (i == 4000) apply_reset(0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
